// File: rtl/banco_reg_sb_if.sv
// rtl/banco_reg_sb_if.sv - register file read/write/reserve bus
//  Groups the two read ports (dl/q/b), the write port (we/de/dato) and
//  the reservation port (rsv/dr) of banco_reg_sb.
//  master: the datapath that drives addresses, writes and reservations.
//  slave : the register file, which returns read data and busy flags.
interface banco_reg_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] dl1;
  logic [AW-1:0] dl2;
  logic [DW-1:0] q1;
  logic [DW-1:0] q2;
  logic          b1;
  logic          b2;
  logic          we;
  logic [AW-1:0] de;
  logic [DW-1:0] dato;
  logic          rsv;
  logic [AW-1:0] dr;

  modport master (
    output dl1, dl2, we, de, dato, rsv, dr,
    input  q1, q2, b1, b2
  );

  modport slave (
    input  dl1, dl2, we, de, dato, rsv, dr,
    output q1, q2, b1, b2
  );
endinterface

// File: rtl/banco_reg_sb.sv
// rtl/banco_reg_sb.sv - multi-read register file with busy scoreboard
//  Two combinational read ports, one clocked write port, optional hard-zero
//  register 0, optional write-to-read bypass and a per-register busy bit
//  set by a reservation and cleared by the write that resolves it.
//  Ports:
//    clk   : clock, all state changes on the rising edge
//    rst_n : asynchronous active-low reset, clears data and busy bits
//    bus   : banco_reg_sb_if.slave (read ports, write port, reservation)
module banco_reg_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  banco_reg_sb_if.slave     bus
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_ok;

  // A write to the hard-zero register is dropped entirely.
  assign wr_ok = bus.we && !((ZERO_R0 != 0) && (bus.de == '0));

  // Clear on write first, then set on reserve, so a same-register
  // reserve+write leaves the register busy for the newly issued producer.
  always_comb begin
    busy_nxt = busy;
    if (bus.we)  busy_nxt[bus.de] = 1'b0;
    if (bus.rsv) busy_nxt[bus.dr] = 1'b1;
    if (ZERO_R0 != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) mem[bus.de] <= bus.dato;
      busy <= busy_nxt;
    end
  end

  // Forwarding is suppressed while in reset so the outputs stay 0 even if
  // a write is being presented.
  logic fwd1, fwd2;
  assign fwd1 = (BYPASS != 0) && rst_n && bus.we && (bus.de == bus.dl1);
  assign fwd2 = (BYPASS != 0) && rst_n && bus.we && (bus.de == bus.dl2);

  always_comb begin
    bus.q1 = mem[bus.dl1];
    bus.b1 = busy[bus.dl1];
    if ((ZERO_R0 != 0) && (bus.dl1 == '0)) begin
      bus.q1 = '0;
      bus.b1 = 1'b0;
    end else if (fwd1) begin
      bus.q1 = bus.dato;
      bus.b1 = 1'b0;
    end
  end

  always_comb begin
    bus.q2 = mem[bus.dl2];
    bus.b2 = busy[bus.dl2];
    if ((ZERO_R0 != 0) && (bus.dl2 == '0)) begin
      bus.q2 = '0;
      bus.b2 = 1'b0;
    end else if (fwd2) begin
      bus.q2 = bus.dato;
      bus.b2 = 1'b0;
    end
  end
endmodule

// File: tb/tb_banco_reg_sb.sv
// tb/tb_banco_reg_sb.sv - self-checking bench for banco_reg_sb
module tb_banco_reg_sb;
  logic clk;
  logic rst_n;

  banco_reg_sb_if #(.DW(32), .AW(5)) ifa ();
  banco_reg_sb_if #(.DW(32), .AW(5)) ifb ();
  banco_reg_sb_if #(.DW(8),  .AW(3)) ifc ();

  banco_reg_sb #(.DW(32), .AW(5), .ZERO_R0(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  banco_reg_sb #(.DW(32), .AW(5), .ZERO_R0(0), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  banco_reg_sb #(.DW(8),  .AW(3), .ZERO_R0(1), .BYPASS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  de;
    logic [31:0] dato;
    logic        rsv;
    logic [4:0]  dr;
    logic [4:0]  dl1;
    logic [4:0]  dl2;
    logic [31:0] q1;
    logic        b1;
    logic [31:0] q2;
    logic        b2;
  } vec_t;

  vec_t vt [19];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    ifa.we = 0; ifa.de = 0; ifa.dato = 0; ifa.rsv = 0; ifa.dr = 0; ifa.dl1 = 0; ifa.dl2 = 0;
    ifb.we = 0; ifb.de = 0; ifb.dato = 0; ifb.rsv = 0; ifb.dr = 0; ifb.dl1 = 0; ifb.dl2 = 0;
    ifc.we = 0; ifc.de = 0; ifc.dato = 0; ifc.rsv = 0; ifc.dr = 0; ifc.dl1 = 0; ifc.dl2 = 0;
  endtask

  initial begin
    //       we de  dato          rsv dr  dl1 dl2  q1            b1  q2            b2
    vt[0]  = '{0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        0, 32'h0,        0};
    vt[1]  = '{1, 5,  32'hCAFE0005, 0, 0,  5,  5,  32'hCAFE0005, 0, 32'hCAFE0005, 0};
    vt[2]  = '{0, 0,  32'h0,        0, 0,  5,  0,  32'hCAFE0005, 0, 32'h0,        0};
    vt[3]  = '{1, 0,  32'hFFFFFFFF, 0, 0,  0,  0,  32'h0,        0, 32'h0,        0};
    vt[4]  = '{0, 0,  32'h0,        0, 0,  0,  5,  32'h0,        0, 32'hCAFE0005, 0};
    vt[5]  = '{0, 0,  32'h0,        1, 7,  5,  7,  32'hCAFE0005, 0, 32'h0,        0};
    vt[6]  = '{0, 0,  32'h0,        0, 0,  7,  7,  32'h0,        1, 32'h0,        1};
    vt[7]  = '{0, 0,  32'h0,        0, 0,  5,  7,  32'hCAFE0005, 0, 32'h0,        1};
    vt[8]  = '{1, 7,  32'h77,       0, 0,  7,  7,  32'h77,       0, 32'h77,       0};
    vt[9]  = '{0, 0,  32'h0,        0, 0,  7,  7,  32'h77,       0, 32'h77,       0};
    vt[10] = '{1, 9,  32'h99,       1, 9,  9,  3,  32'h99,       0, 32'h0,        0};
    vt[11] = '{0, 0,  32'h0,        0, 0,  9,  9,  32'h99,       1, 32'h99,       1};
    vt[12] = '{0, 0,  32'h0,        1, 0,  0,  9,  32'h0,        0, 32'h99,       1};
    vt[13] = '{0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        0, 32'h0,        0};
    vt[14] = '{0, 0,  32'h0,        1, 9,  9,  7,  32'h99,       1, 32'h77,       0};
    vt[15] = '{0, 0,  32'h0,        0, 0,  9,  9,  32'h99,       1, 32'h99,       1};
    vt[16] = '{1, 9,  32'h55,       0, 0,  9,  9,  32'h55,       0, 32'h55,       0};
    vt[17] = '{0, 0,  32'h0,        0, 0,  9,  5,  32'h55,       0, 32'hCAFE0005, 0};
    vt[18] = '{1, 31, 32'h1F1F,     0, 0,  31, 30, 32'h1F1F,     0, 32'h0,        0};

    idle_all();
    rst_n = 1'b0;
    #1;
    chk("rst_q1", ifa.q1, 32'h0);
    chk("rst_b1", {31'h0, ifa.b1}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table vectors on the bypassing, hard-zero instance.
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      ifa.we = vt[i].we; ifa.de = vt[i].de; ifa.dato = vt[i].dato;
      ifa.rsv = vt[i].rsv; ifa.dr = vt[i].dr;
      ifa.dl1 = vt[i].dl1; ifa.dl2 = vt[i].dl2;
      @(negedge clk);
      chk($sformatf("v%0d_q1", i), ifa.q1, vt[i].q1);
      chk($sformatf("v%0d_b1", i), {31'h0, ifa.b1}, {31'h0, vt[i].b1});
      chk($sformatf("v%0d_q2", i), ifa.q2, vt[i].q2);
      chk($sformatf("v%0d_b2", i), {31'h0, ifa.b2}, {31'h0, vt[i].b2});
    end
    @(posedge clk); #1 idle_all();

    // No bypass, no hard zero: new value appears only after the edge.
    ifb.we = 1; ifb.de = 5; ifb.dato = 32'hCAFE0005; ifb.dl1 = 5;
    @(negedge clk) chk("b_old_same_cycle", ifb.q1, 32'h0);
    @(posedge clk); #1 ifb.we = 0;
    @(negedge clk) chk("b_new_next_cycle", ifb.q1, 32'hCAFE0005);
    @(posedge clk); #1 ifb.we = 1; ifb.de = 0; ifb.dato = 32'hFFFFFFFF; ifb.dl1 = 0;
    @(negedge clk) chk("b_r0_before", ifb.q1, 32'h0);
    @(posedge clk); #1 ifb.we = 0;
    @(negedge clk) chk("b_r0_written", ifb.q1, 32'hFFFFFFFF);
    @(posedge clk); #1 ifb.rsv = 1; ifb.dr = 7; ifb.dl2 = 7;
    @(negedge clk) chk("b_b2_before_rsv", {31'h0, ifb.b2}, 32'h0);
    @(posedge clk); #1 ifb.rsv = 0;
    @(negedge clk) chk("b_b2_reserved", {31'h0, ifb.b2}, 32'h1);
    @(posedge clk); #1 ifb.we = 1; ifb.de = 7; ifb.dato = 32'h77;
    @(negedge clk);
    chk("b_b2_not_masked", {31'h0, ifb.b2}, 32'h1);
    chk("b_q2_not_fwd", ifb.q2, 32'h0);
    @(posedge clk); #1 ifb.we = 0;
    @(negedge clk);
    chk("b_b2_cleared", {31'h0, ifb.b2}, 32'h0);
    chk("b_q2_written", ifb.q2, 32'h77);

    // Narrow build: fill all 8 addresses then read back on both ports.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ifc.we = 1; ifc.de = 3'(i); ifc.dato = 8'h10 + 8'(i);
    end
    @(posedge clk); #1 ifc.we = 0;
    for (int i = 0; i < 8; i++) begin
      ifc.dl1 = 3'(i); ifc.dl2 = 3'(7 - i);
      #1;
      chk($sformatf("c_q1_a%0d", i), {24'h0, ifc.q1}, (i == 0) ? 32'h0 : 32'h10 + i);
      chk($sformatf("c_q2_a%0d", 7 - i), {24'h0, ifc.q2}, (i == 7) ? 32'h0 : 32'h17 - i);
    end

    // Asynchronous reset mid-cycle with data and a pending reservation.
    @(posedge clk); #1 ifa.rsv = 1; ifa.dr = 12;
    @(posedge clk); #1 ifa.rsv = 0; ifa.dl1 = 12;
    @(negedge clk) chk("a_b1_pre_reset", {31'h0, ifa.b1}, 32'h1);
    #2 rst_n = 1'b0;
    ifa.we = 1; ifa.de = 5; ifa.dato = 32'hAA;
    for (int i = 0; i < 32; i++) begin
      ifa.dl1 = 5'(i); ifa.dl2 = 5'(i); ifb.dl1 = 5'(i);
      #1;
      chk($sformatf("r_q1_a%0d", i), ifa.q1, 32'h0);
      chk($sformatf("r_b1_a%0d", i), {31'h0, ifa.b1}, 32'h0);
      chk($sformatf("r_q2_a%0d", i), ifa.q2, 32'h0);
      chk($sformatf("r_b2_a%0d", i), {31'h0, ifa.b2}, 32'h0);
      chk($sformatf("r_bq1_a%0d", i), ifb.q1, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
